// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the CPU register bank and its writeback path.
//   REG_COUNT / REG_ADDR_WIDTH / DATA_WIDTH : default architectural sizes
//   FIFO_DEPTH                               : default writeback buffer depth
//   wb_entry_t                               : one buffered write {rd, data}
//   SB_WIDTH / SB_MAX                        : pending-scoreboard counter size
package cpu_pkg;

    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT);
    localparam int DATA_WIDTH     = 32;
    localparam int FIFO_DEPTH     = 4;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     data;
    } wb_entry_t;

    // Each register can have up to three writes in flight before issue stalls.
    localparam int                  SB_WIDTH = 2;
    localparam logic [SB_WIDTH-1:0] SB_MAX   = '1;

endpackage

// File: rtl/cpu_wb_fifo.sv
// cpu_wb_fifo
// Synchronous circular-buffer FIFO. Pushes while full and pops while empty
// are ignored; a simultaneous push and pop leaves the count unchanged.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, push_data : write request and payload
//   pop          : advance the head
//   head         : entry at the head (valid when !empty)
//   full, empty, count : occupancy, count runs 0..DEPTH
module cpu_wb_fifo #(
    parameter  int WIDTH = 37,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_bank_writeback.sv
// cpu_bank_writeback
// Write-side initiator for the register bank's single write port. Accepts
// results from the memory-load and ALU producers (mem has priority), buffers
// them in cpu_wb_fifo, and drains one entry per cycle into registered
// write_enable/write_reg/write_data. Writes to register 0 are dropped.
// A 2-bit per-register scoreboard counts reserved-but-uncommitted writes.
//   clock, reset                    : rising edge, synchronous active-high
//   mem_valid/ready, mem_reg/data   : load result handshake
//   alu_valid/ready, alu_reg/data   : ALU result handshake
//   reserve_valid/ready, reserve_reg: issue marks a destination pending
//   query_reg_a/b -> pending_a/b    : combinational pending lookup
//   write_enable/reg/data           : registered bank write port
module cpu_bank_writeback #(
    parameter  int REG_COUNT      = cpu_pkg::REG_COUNT,
    parameter  int DATA_WIDTH     = cpu_pkg::DATA_WIDTH,
    parameter  int FIFO_DEPTH     = cpu_pkg::FIFO_DEPTH,
    localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [REG_ADDR_WIDTH-1:0] mem_reg,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [REG_ADDR_WIDTH-1:0] alu_reg,
    input  logic [DATA_WIDTH-1:0]     alu_data,
    input  logic                      reserve_valid,
    input  logic [REG_ADDR_WIDTH-1:0] reserve_reg,
    output logic                      reserve_ready,
    input  logic [REG_ADDR_WIDTH-1:0] query_reg_a,
    input  logic [REG_ADDR_WIDTH-1:0] query_reg_b,
    output logic                      pending_a,
    output logic                      pending_b,
    output logic                      write_enable,
    output logic [REG_ADDR_WIDTH-1:0] write_reg,
    output logic [DATA_WIDTH-1:0]     write_data
);
    import cpu_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Same layout as wb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     data;
    } entry_t;

    entry_t             push_entry;
    entry_t             head_entry;
    logic               mem_fire;
    logic               alu_fire;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               reserve_fire;
    logic [SB_WIDTH-1:0] sb_cnt [REG_COUNT];

    // Readies look only at registered occupancy; a slot freed by this
    // cycle's pop is not offered until the next cycle.
    assign mem_ready = !fifo_full;
    assign alu_ready = !fifo_full && !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;
    assign push      = mem_fire || alu_fire;
    assign pop       = !fifo_empty;

    always_comb begin
        push_entry = '{rd: alu_reg, data: alu_data};
        if (mem_fire) begin
            push_entry = '{rd: mem_reg, data: mem_data};
        end
    end

    cpu_wb_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Register-0 entries still drain (keeping order and throughput) but
    // never raise write_enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_enable <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
        end else if (pop) begin
            write_enable <= (head_entry.rd != '0);
            write_reg    <= head_entry.rd;
            write_data   <= head_entry.data;
        end else begin
            write_enable <= 1'b0;
        end
    end

    // Counter 0 never moves, so reserve_ready and pending for register 0
    // fall out of the same lookups without special-casing the read side.
    assign reserve_ready = (sb_cnt[reserve_reg] != SB_MAX);
    assign reserve_fire  = reserve_valid && reserve_ready && (reserve_reg != '0);
    assign pending_a     = (sb_cnt[query_reg_a] != '0);
    assign pending_b     = (sb_cnt[query_reg_b] != '0);

    always_ff @(posedge clock) begin
        for (int r = 0; r < REG_COUNT; r++) begin
            if (reset) begin
                sb_cnt[r] <= '0;
            end else begin
                // Reserve and commit on the same register cancel out; a
                // commit to a register with nothing reserved is absorbed.
                if (reserve_fire && (reserve_reg == REG_ADDR_WIDTH'(r))) begin
                    if (!(write_enable && (write_reg == REG_ADDR_WIDTH'(r)))) begin
                        sb_cnt[r] <= sb_cnt[r] + 1'b1;
                    end
                end else if (write_enable && (write_reg == REG_ADDR_WIDTH'(r))
                             && (sb_cnt[r] != '0)) begin
                    sb_cnt[r] <= sb_cnt[r] - 1'b1;
                end
            end
        end
    end

    // Readies are derived from occupancy, so occupancy can never exceed depth.
    assert property (@(posedge clock) disable iff (reset)
                     fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule
